// File: rtl/popcnt_pkg.sv
// Shared types and width helper for the streaming population counter.
package popcnt_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Bits needed to hold any value in 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcnt_word.sv
// Combinational popcount of a single W-bit word.
module popcnt_word #(
    parameter int W  = 8,
    localparam int PW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [PW-1:0] o_cnt
);

    // Ripple-sum of every bit; synthesis rebalances into an adder tree.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < W; i++) begin
            o_cnt = o_cnt + PW'(i_data[i]);
        end
    end

endmodule

// File: rtl/popcnt_stream.sv
// Streaming per-frame population counter with valid/ready in and out.
// Optional macro POPCNT_ZEROS_EN adds o_out_zeros (clear bits in counted words).
module popcnt_stream
    import popcnt_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_WORDS = 4,
    localparam int CW       = cnt_width(W * MAX_WORDS),
    localparam int WW       = cnt_width(MAX_WORDS),
    localparam int PW       = $clog2(W + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    input  logic [W-1:0]  i_in_data,
    input  logic          i_in_last,
    output logic          o_in_ready,
    output logic          o_out_valid,
    output logic [CW-1:0] o_out_cnt,
    output logic [WW-1:0] o_out_words,
    output logic          o_out_ovf,
`ifdef POPCNT_ZEROS_EN
    output logic [CW-1:0] o_out_zeros,
`endif
    input  logic          i_out_ready
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_words;
    logic          r_ovf;
    logic [PW-1:0] w_pc;
    logic          w_beat;
    logic          w_take;
    logic          w_consume;

    popcnt_word #(.W(W)) u_word (
        .i_data (i_in_data),
        .o_cnt  (w_pc)
    );

    assign w_beat    = i_in_valid && o_in_ready;
    assign w_consume = o_out_valid && i_out_ready;
    // Beats past MAX_WORDS are swallowed and only flag overflow.
    assign w_take    = w_beat && (r_words < WW'(MAX_WORDS));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ACC;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake decode from registered state.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            ACC: begin
                o_in_ready = 1'b1;
                if (i_in_valid && i_in_last) w_state_nxt = DONE;
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_state_nxt = ACC;
            end
            default: w_state_nxt = ACC;
        endcase
    end

    // Accumulator, word counter and sticky overflow; frozen while in DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_consume) begin
            r_cnt   <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
        end else if (w_take) begin
            r_cnt   <= r_cnt + CW'(w_pc);
            r_words <= r_words + WW'(1);
        end else if (w_beat) begin
            r_ovf   <= 1'b1;
        end
    end

    assign o_out_cnt   = r_cnt;
    assign o_out_words = r_words;
    assign o_out_ovf   = r_ovf;

`ifdef POPCNT_ZEROS_EN
    logic [CW-1:0] r_zeros;

    // Clear-bit tally, only over words that were actually counted.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_consume) r_zeros <= '0;
        else if (w_take)        r_zeros <= r_zeros + CW'(W) - CW'(w_pc);
    end

    assign o_out_zeros = r_zeros;
`endif

endmodule
